// File: rtl/adc_spi_responder.sv
// Serial ADC responder: returns a 12-bit sample from one of eight channels per
// 16-bit frame and latches the channel address carried in the master's control word.
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        din,
   input  logic [95:0] sample_bus,
   output logic        dout,
   output logic [2:0]  cur_addr,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   genvar gi;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_din_sync;
   logic                   r_sclk_prev;
   logic                   r_cs_prev;
   logic [SYNC_STAGES:0]   r_valid;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_shift;
   logic [4:0]  r_rise_cnt;
   logic [2:0]  r_pend_addr;
   logic [2:0]  r_cur_addr;
   logic        r_frame_done;
   logic        r_dout;

   logic        w_sclk;
   logic        w_cs;
   logic        w_din;
   logic        w_sclk_rise;
   logic        w_sclk_fall;
   logic        w_cs_fall;
   logic        w_cs_rise;
   logic        w_load;
   logic        w_shift;
   logic        w_rise;
   logic        w_done;
   logic [11:0] w_chan [8];

   // r_valid marks when every flop in the sync chain and the edge-history flop
   // holds a genuine post-reset sample; only then may a cs_n fall start a frame,
   // so a cs_n held low through reset cannot masquerade as a fresh fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '1;
         r_cs_sync   <= '1;
         r_din_sync  <= '0;
         r_sclk_prev <= 1'b1;
         r_cs_prev   <= 1'b1;
         r_valid     <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din};
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
         r_valid     <= {r_valid[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_din       = r_din_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk & r_sclk_prev;
   assign w_cs_fall   = ~w_cs & r_cs_prev & r_valid[SYNC_STAGES];
   assign w_cs_rise   = w_cs & ~r_cs_prev;

   generate
      for (gi = 0; gi < 8; gi++) begin : g_chan
         assign w_chan[gi] = sample_bus[12*gi +: 12];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_cs_rise) begin
               w_state_next = ST_IDLE;
            end else if (w_sclk_rise && (r_rise_cnt == 5'd15)) begin
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (w_cs_rise) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // In IDLE the sclk edges never qualify, which also gives the cs_n fall
   // priority over an sclk edge seen in the same cycle.
   always_comb begin
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_rise  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         ST_IDLE:  w_load = w_cs_fall;
         ST_SHIFT: begin
            w_shift = w_sclk_fall & ~w_cs_rise;
            w_rise  = w_sclk_rise & ~w_cs_rise;
            w_done  = w_sclk_rise & ~w_cs_rise & (r_rise_cnt == 5'd15);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift      <= '0;
         r_rise_cnt   <= '0;
         r_pend_addr  <= '0;
         r_cur_addr   <= '0;
         r_frame_done <= 1'b0;
         r_dout       <= 1'b0;
      end else begin
         r_frame_done <= w_done;
         r_dout       <= (r_state == ST_SHIFT) ? r_shift[15] : 1'b0;
         if (w_load) begin
            r_shift     <= {4'b0000, w_chan[r_cur_addr]};
            r_rise_cnt  <= '0;
            r_pend_addr <= '0;
         end else begin
            if (w_shift) begin
               r_shift <= {r_shift[14:0], 1'b0};
            end
            if (w_rise) begin
               r_rise_cnt <= r_rise_cnt + 5'd1;
               case (r_rise_cnt)
                  5'd2:    r_pend_addr[2] <= w_din;
                  5'd3:    r_pend_addr[1] <= w_din;
                  5'd4:    r_pend_addr[0] <= w_din;
                  default: ;
               endcase
            end
            if (w_done) begin
               r_cur_addr <= r_pend_addr;
            end
         end
      end
   end

   assign dout       = r_dout;
   assign cur_addr   = r_cur_addr;
   assign frame_done = r_frame_done;

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on sclk, cs_n and din (legal range 2..3).
REQ-002 SHALL have port clk, input, 1, system clock, with all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, which is synchronous and active-high.
REQ-004 SHALL have port sclk, input, 1, serial clock from the ADC master (2 MHz class), which idles high and is asynchronous to clk.
REQ-005 SHALL have port cs_n, input, 1, active-low frame select from the master.
REQ-006 SHALL have port din, input, 1, control word bits from the master, MSB first.
REQ-007 SHALL have port sample_bus, input, 96, with channel n value at bits [12n+11:12n], n = 0..7.
REQ-008 SHALL have port dout, output, 1, serial conversion result to the master.
REQ-009 SHALL have port cur_addr, output, 3, the channel address that will be returned in the next frame.
REQ-010 SHALL have port frame_done, output, 1, a one-clk pulse on completion of a valid 16-bit frame.

Function
REQ-011 SHALL pass sclk, cs_n and din each through SYNC_STAGES flops before use; all edge detection SHALL be done on the synchronized signals, comparing the current and previous synchronized values.
REQ-012 SHALL define a frame as the interval from a cs_n falling edge to the next cs_n rising edge.
REQ-013 SHALL use an FSM with states IDLE, SHIFT and HOLD:
- IDLE→SHIFT on a cs_n fall.
- SHIFT→HOLD after the 16th sclk rise.
- SHIFT or HOLD→IDLE on a cs_n rise.
REQ-014 On the cs_n fall, SHALL load a 16-bit shift register with {4'b0000, sample_bus[12*cur_addr +: 12]} and drive dout = bit 15 (0).
REQ-015 On each synchronized sclk fall in SHIFT, SHALL shift the register left by one, fill with 0, and drive dout = new bit 15; the 12 data bits therefore appear MSB first after falls 4..15.
REQ-016 SHALL update dout registered, exactly SYNC_STAGES+1 clk cycles after the pin-level sclk fall or cs_n fall is first sampled.
REQ-017 SHALL sample din on each synchronized sclk rise in SHIFT and keep a rise counter of 0..16.
- Rises 3, 4 and 5 SHALL capture ADD2, ADD1 and ADD0 into a pending address.
- All other rises SHALL ignore din.
REQ-018 On the 16th rise, SHALL copy the pending address to cur_addr and pulse frame_done high for exactly one clk.
REQ-019 A cs_n rise before the 16th rise SHALL abort the frame: cur_addr is unchanged, no frame_done pulse, FSM→IDLE.
REQ-020 sclk edges in HOLD SHALL be ignored, and dout SHALL hold 0.
REQ-021 sclk edges in IDLE SHALL be ignored.
REQ-022 In IDLE, dout SHALL be 0; there is no tri-state.
REQ-023 If a cs_n fall and an sclk edge are detected in the same clk, the cs_n fall SHALL take priority and the sclk edge SHALL be discarded.
REQ-024 sample_bus SHALL be read only at the load point; changes mid-frame SHALL not affect the frame in progress.
REQ-025 The first frame after reset SHALL return channel 0.

Reset
REQ-026 While rst = 1 at a clk rise, the following SHALL be forced: FSM = IDLE, dout = 0, cur_addr = 0, frame_done = 0, shift register = 0, rise counter = 0, pending address = 0.
REQ-027 While rst = 1, the sclk and cs_n synchronizer flops SHALL be forced to 1, and the din synchronizer flops to 0, so that no spurious edge is detected after reset.
REQ-028 An rst asserted mid-frame SHALL abandon the frame.
REQ-029 After rst deasserts, the block SHALL wait for a fresh cs_n fall; a cs_n already held low SHALL not start a frame until it goes high and then falls again.

Verification
REQ-030 Scenario 1: sample_bus ch0 = 12'hA5C; after reset, one 16-clock frame with din = 0 → dout bits = 0000_1010_0101_1100, one frame_done pulse, cur_addr = 0.
REQ-031 Scenario 2: frame 1 sends control word 16'h2800 (ADD = 3'b101), ch5 = 12'h3C7 → after frame 1, cur_addr = 5; frame 2 returns 0000_0011_1100_0111.
REQ-032 Scenario 3: cs_n raised after 9 sclk rises in a frame carrying ADD = 3'b011 → no frame_done, cur_addr unchanged, dout = 0, and the next full frame returns the previous channel.
REQ-033 Scenario 4: 20 sclk cycles within one cs_n-low window → frame_done pulses once at rise 16, and dout = 0 for falls 16..19.
REQ-034 Scenario 5: rst pulsed for one clk after sclk rise 7 of a frame with ADD = 3'b110 → all outputs return to reset values, cur_addr = 0, and the next frame returns ch0.
REQ-035 Scenario 6: ch2 changed from 12'h111 to 12'hFFF after bit 6 of a ch2 frame → the full frame still shifts out 12'h111.
